display_scan_controller: RTL and testbench

Time-multiplexes one shared hex-to-seven-segment decoder across `DIGITS` common-anode digits. It holds a double-buffered digit store and scans the digits at a fixed refresh rate. Each digit slot is preceded by an anti-ghosting blank interval. It sits between the system logic, which writes digit values, and the existing 4-bit-in, active-low-segment decoder, which receives `Nibble` each slot.

---
 rtl/display_scan_controller_pkg.sv | 17 +
 rtl/display_scan_controller_scan_tick_gen.sv | 38 +++
 rtl/display_scan_controller.sv | 131 +++++++++++++
 tb/tb_display_scan_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package display_scan_controller_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_e;

   localparam int DEF_PRESCALE     = 50000;
   localparam int DEF_BLANK_CYCLES = 2;

   // Digit address width, never narrower than one bit.
   function automatic int addr_width(input int digits);
      return (digits > 2) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/display_scan_controller_scan_tick_gen.sv
// Modulo-PRESCALE slot counter with end-of-slot and end-of-blank flags.
module scan_tick_gen
   import display_scan_controller_pkg::*;
#(
   parameter int PRESCALE     = DEF_PRESCALE,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
   parameter int CW           = $clog2(PRESCALE)
) (
   input  logic          Clk,
   input  logic          Reset_n,
   output logic [CW-1:0] slot_cnt,
   output logic          slot_end,
   output logic          blank_end
);

   localparam logic [CW-1:0] CNT_LAST      = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);

   logic [CW-1:0] slot_cnt_q;
   logic [CW-1:0] slot_cnt_d;

   assign slot_cnt  = slot_cnt_q;
   assign slot_end  = (slot_cnt_q == CNT_LAST);
   assign blank_end = (slot_cnt_q == CNT_BLANK_END);

   always_comb begin
      slot_cnt_d = slot_end ? '0 : slot_cnt_q + 1'b1;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         slot_cnt_q <= '0;
      end else begin
         slot_cnt_q <= slot_cnt_d;
      end
   end

endmodule

// File: rtl/display_scan_controller.sv
// Double-buffered digit store scanned across DIGITS common-anode digits,
// with an all-anodes-off blank interval at the start of every slot.
module display_scan_controller
   import display_scan_controller_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int PRESCALE     = DEF_PRESCALE,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
   parameter int AW           = addr_width(DIGITS)
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Wr_En,
   input  logic [AW-1:0]     Wr_Addr,
   input  logic [3:0]        Wr_Data,
   input  logic              Commit,
   input  logic [DIGITS-1:0] Enable,
   output logic [3:0]        Nibble,
   output logic [DIGITS-1:0] Anode_n,
   output logic              Commit_Pending,
   output logic              Frame_Done
);

   localparam int            CW          = $clog2(PRESCALE);
   localparam logic [AW-1:0] DIG_LAST    = AW'(DIGITS - 1);
   localparam logic [CW-1:0] CNT_PRE_END = CW'(PRESCALE - 2);

   logic [CW-1:0]     slot_cnt;
   logic              slot_end;
   logic              blank_end;
   logic              frame_end;
   logic [AW-1:0]     dig_nxt;
   logic [DIGITS-1:0] drive_pat;

   scan_state_e       state_q, state_d;
   logic [AW-1:0]     dig_q, dig_d;
   logic [3:0]        shadow_q [DIGITS];
   logic [3:0]        shadow_d [DIGITS];
   logic [3:0]        active_q [DIGITS];
   logic [3:0]        active_d [DIGITS];
   logic [3:0]        nibble_q, nibble_d;
   logic [DIGITS-1:0] anode_q, anode_d;
   logic              pending_q, pending_d;
   logic              frame_done_q, frame_done_d;

   scan_tick_gen #(
      .PRESCALE     (PRESCALE),
      .BLANK_CYCLES (BLANK_CYCLES),
      .CW           (CW)
   ) u_tick (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .slot_cnt  (slot_cnt),
      .slot_end  (slot_end),
      .blank_end (blank_end)
   );

   always_comb begin
      frame_end    = slot_end && (dig_q == DIG_LAST);
      dig_nxt      = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
      dig_d        = slot_end ? dig_nxt : dig_q;
      shadow_d     = shadow_q;
      active_d     = active_q;
      pending_d    = pending_q | Commit;
      state_d      = state_q;
      anode_d      = anode_q;
      nibble_d     = nibble_q;
      frame_done_d = (slot_cnt == CNT_PRE_END) && (dig_q == DIG_LAST);

      // Addresses beyond the last digit match no slot and are dropped.
      for (int i = 0; i < DIGITS; i++) begin
         if (Wr_En && (Wr_Addr == AW'(i))) shadow_d[i] = Wr_Data;
         drive_pat[i] = !((dig_q == AW'(i)) && Enable[i]);
      end

      // The copy uses shadow as it stood before this edge; a coincident Commit re-arms.
      if (frame_end && pending_q) begin
         active_d  = shadow_q;
         pending_d = Commit;
      end

      if (state_q == ST_BLANK) begin
         if (blank_end) begin
            state_d = ST_DRIVE;
            anode_d = drive_pat;
         end else begin
            anode_d = '1;
         end
      end else begin
         if (slot_end) begin
            state_d = ST_BLANK;
            anode_d = '1;
            for (int i = 0; i < DIGITS; i++) begin
               if (dig_nxt == AW'(i)) nibble_d = active_d[i];
            end
         end else begin
            anode_d = drive_pat;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= ST_BLANK;
         dig_q        <= '0;
         nibble_q     <= '0;
         anode_q      <= '1;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         dig_q        <= dig_d;
         nibble_q     <= nibble_d;
         anode_q      <= anode_d;
         pending_q    <= pending_d;
         frame_done_q <= frame_done_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
      end
   end

   assign Nibble         = nibble_q;
   assign Anode_n        = anode_q;
   assign Commit_Pending = pending_q;
   assign Frame_Done     = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomised and directed bench for display_scan_controller against a time-indexed reference model.
module tb_display_scan_controller;

   localparam int D = 4;
   localparam int P = 8;
   localparam int B = 2;
   localparam int F = D * P;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       Wr_En;
   logic [1:0] Wr_Addr;
   logic [3:0] Wr_Data;
   logic       Commit;
   logic [3:0] Enable;
   logic [3:0] Nibble;
   logic [3:0] Anode_n;
   logic       Commit_Pending;
   logic       Frame_Done;

   int checks = 0;
   int errors = 0;

   // Reference model: t counts cycles since reset release.
   int         t;
   logic [3:0] sh [D];
   logic [3:0] ac [D];
   logic       pend;
   logic [3:0] nib;
   logic [3:0] en_prev;

   display_scan_controller #(
      .DIGITS       (D),
      .PRESCALE     (P),
      .BLANK_CYCLES (B)
   ) dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .Wr_En          (Wr_En),
      .Wr_Addr        (Wr_Addr),
      .Wr_Data        (Wr_Data),
      .Commit         (Commit),
      .Enable         (Enable),
      .Nibble         (Nibble),
      .Anode_n        (Anode_n),
      .Commit_Pending (Commit_Pending),
      .Frame_Done     (Frame_Done)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h (t=%0d time=%0t)", tag, got, exp, t, $time);
      end
   endtask

   function automatic logic [3:0] exp_anode();
      int s;
      int dg;
      s  = t % P;
      dg = (t / P) % D;
      if (s < B) return 4'hF;
      if (en_prev[dg]) return ~(4'b0001 << dg);
      return 4'hF;
   endfunction

   task automatic model_reset();
      t       = 0;
      pend    = 1'b0;
      nib     = 4'h0;
      en_prev = 4'hF;
      for (int i = 0; i < D; i++) begin
         sh[i] = 4'h0;
         ac[i] = 4'h0;
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_anode", 32'(Anode_n), 32'hF);
      check("rst_nibble", 32'(Nibble), 32'h0);
      check("rst_pending", 32'(Commit_Pending), 32'h0);
      check("rst_frame_done", 32'(Frame_Done), 32'h0);
   endtask

   // Called just after a falling edge: checks cycle t, drives inputs, advances one clock.
   task automatic step(input logic we, input logic [1:0] a, input logic [3:0] d,
                       input logic cm, input logic [3:0] en);
      check("anode", 32'(Anode_n), 32'(exp_anode()));
      check("nibble", 32'(Nibble), 32'(nib));
      check("pending", 32'(Commit_Pending), 32'(pend));
      check("frame_done", 32'(Frame_Done), 32'((t % F) == (F - 1)));
      Wr_En   = we;
      Wr_Addr = a;
      Wr_Data = d;
      Commit  = cm;
      Enable  = en;
      if (((t % F) == (F - 1)) && pend) begin
         for (int i = 0; i < D; i++) ac[i] = sh[i];
         pend = cm;
      end else begin
         pend = pend | cm;
      end
      if (we) sh[a] = d;
      en_prev = en;
      t++;
      if ((t % P) == 0) nib = ac[(t / P) % D];
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic idle(input int n, input logic [3:0] en);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 4'h0, 1'b0, en);
   endtask

   initial begin
      logic       rwe;
      logic [1:0] ra;
      logic [3:0] rd;
      logic       rcm;
      logic [3:0] ren;

      Reset_n = 1'b0;
      Wr_En   = 1'b0;
      Wr_Addr = 2'd0;
      Wr_Data = 4'h0;
      Commit  = 1'b0;
      Enable  = 4'hF;
      model_reset();
      repeat (3) @(negedge Clk);
      check_reset_outputs();
      Reset_n = 1'b1;

      // Idle after reset: blank/drive pattern and frame pulse every F cycles.
      idle(2 * F, 4'hF);

      // Load 3,5,A,F and commit together with the last write.
      step(1'b1, 2'd0, 4'h3, 1'b0, 4'hF);
      step(1'b1, 2'd1, 4'h5, 1'b0, 4'hF);
      step(1'b1, 2'd2, 4'hA, 1'b0, 4'hF);
      step(1'b1, 2'd3, 4'hF, 1'b1, 4'hF);
      idle(2 * F + 16, 4'hF);

      // Shadow-only write stays invisible.
      step(1'b1, 2'd2, 4'h7, 1'b0, 4'hF);
      idle(3 * F, 4'hF);

      // Commit pending, then Commit + write exactly on the boundary cycle.
      step(1'b0, 2'd0, 4'h0, 1'b1, 4'hF);
      while ((t % F) != (F - 1)) step(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);
      step(1'b1, 2'd0, 4'h9, 1'b1, 4'hF);
      idle(2 * F + 8, 4'hF);

      // Digits 0 and 2 disabled.
      idle(2 * F, 4'b1010);

      // Randomised writes, commits and enable changes.
      ren = 4'hF;
      for (int i = 0; i < 800; i++) begin
         rwe = (($urandom % 6) == 0);
         ra  = 2'($urandom_range(0, 3));
         rd  = 4'($urandom);
         rcm = (($urandom % 30) == 0);
         if (($urandom % 20) == 0) ren = 4'($urandom);
         step(rwe, ra, rd, rcm, ren);
      end

      // Asynchronous reset in the middle of digit 2's drive with a commit pending.
      while ((t % F) != 0) step(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);
      step(1'b1, 2'd1, 4'hC, 1'b1, 4'hF);
      while (!(((t / P) % D) == 2 && (t % P) == 4)) step(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);
      check("pending_before_reset", 32'(Commit_Pending), 32'h1);
      #2 Reset_n = 1'b0;
      #1 check_reset_outputs();
      @(negedge Clk);
      Wr_En   = 1'b0;
      Commit  = 1'b0;
      model_reset();
      Reset_n = 1'b1;
      idle(2 * F, 4'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
